// File: rtl/reg_arbiter_if.sv
// Shared-register arbiter bus: four requesters with packed write data,
// plus the grant/register outputs returned by the arbiter.
interface reg_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] D;
  logic [3:0]         gnt;
  logic [WIDTH-1:0]   Q;
  logic [1:0]         owner;
  logic               upd;
  logic               busy;

  modport master (
    output req, D,
    input  gnt, Q, owner, upd, busy
  );

  modport slave (
    input  req, D,
    output gnt, Q, owner, upd, busy
  );
endinterface

// File: rtl/reg_arbiter.sv
// Four-way round-robin arbiter guarding one shared register with a post-write lock.
// Optional REG_ARBITER_PRIO0_EN: requester 0 always wins and leaves the pointer alone.
module reg_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_CYC = 2
) (
  input logic          clk,
  input logic          rst,
  reg_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       win_q, win_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [1:0]       owner_q, owner_d;
  logic             upd_q, upd_d;
  logic             busy_q, busy_d;

  logic             hit;
  logic [1:0]       pick;
  logic [1:0]       idx;

  // Winner search: ascend from ptr with wrap, first set request wins.
  always_comb begin
    hit  = 1'b0;
    pick = ptr_q;
    idx  = ptr_q;
`ifdef REG_ARBITER_PRIO0_EN
    if (bus.req[0]) begin
      hit  = 1'b1;
      pick = 2'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        idx = ptr_q + 2'(k);
        if (!hit && idx != 2'd0 && bus.req[idx]) begin
          hit  = 1'b1;
          pick = idx;
        end
      end
    end
`else
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!hit && bus.req[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = 4'b0000;
    q_d     = q_q;
    owner_d = owner_q;
    upd_d   = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (hit) begin
          state_d = GRANT;
          win_d   = pick;
          gnt_d   = 4'b0001 << pick;
          busy_d  = 1'b1;
`ifdef REG_ARBITER_PRIO0_EN
          if (pick != 2'd0)
            ptr_d = pick + 2'd1;
`else
          ptr_d = pick + 2'd1;
`endif
        end
      end
      GRANT: begin
        q_d     = bus.D[win_q*WIDTH +: WIDTH];
        owner_d = win_q;
        upd_d   = 1'b1;
        if (HOLD_CYC == 0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = HOLD;
          cnt_d   = 8'(HOLD_CYC - 1);
          busy_d  = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      cnt_q   <= 8'd0;
      gnt_q   <= 4'b0000;
      q_q     <= '0;
      owner_q <= 2'd0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.Q     = q_q;
  assign bus.owner = owner_q;
  assign bus.upd   = upd_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter: a HOLD_CYC=2 instance and a HOLD_CYC=0 instance.
// Inputs change and outputs are checked on the falling edge.
module tb_reg_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  reg_arbiter_if #(.WIDTH(W)) a_if ();
  reg_arbiter_if #(.WIDTH(W)) z_if ();

  reg_arbiter #(.WIDTH(W), .HOLD_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  reg_arbiter #(.WIDTH(W), .HOLD_CYC(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (z_if)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input string tag, output logic [3:0] g,
                          output int at);
    g  = 4'b0000;
    at = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (a_if.gnt != 4'b0000) begin
        g  = a_if.gnt;
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed no grant expected a grant", tag);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    a_if.req = 4'b0000;
    z_if.req = 4'b0000;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [3:0] g;
  int         at;
  int         last;
  logic [7:0] exp_q [4];

  initial begin
    exp_q    = '{8'h10, 8'h21, 8'h32, 8'h43};
    a_if.D   = '0;
    z_if.D   = '0;
    do_reset();
    chk("rst_gnt",   32'(a_if.gnt),   32'h0);
    chk("rst_q",     32'(a_if.Q),     32'h0);
    chk("rst_owner", 32'(a_if.owner), 32'h0);
    chk("rst_upd",   32'(a_if.upd),   32'h0);
    chk("rst_busy",  32'(a_if.busy),  32'h0);
    chk("rst_busy0", 32'(z_if.busy),  32'h0);

    // single request from requester 1
    a_if.D   = {8'h00, 8'h00, 8'hA5, 8'h00};
    a_if.req = 4'b0010;
    step();
    chk("s_gnt",  32'(a_if.gnt),  32'h2);
    chk("s_busy", 32'(a_if.busy), 32'h1);
    chk("s_qold", 32'(a_if.Q),    32'h0);
    chk("s_upd0", 32'(a_if.upd),  32'h0);
    a_if.req = 4'b0000;
    step();
    chk("s_q",     32'(a_if.Q),     32'hA5);
    chk("s_owner", 32'(a_if.owner), 32'h1);
    chk("s_upd",   32'(a_if.upd),   32'h1);
    chk("s_gnt0",  32'(a_if.gnt),   32'h0);
    chk("s_busy2", 32'(a_if.busy),  32'h1);
    step();
    chk("s_upd1",  32'(a_if.upd),  32'h0);
    chk("s_busy3", 32'(a_if.busy), 32'h1);
    chk("s_qhold", 32'(a_if.Q),    32'hA5);
    step();
    chk("s_busy4", 32'(a_if.busy), 32'h0);

    // contention, each requester drops after its grant
    do_reset();
    a_if.D   = {8'h43, 8'h32, 8'h21, 8'h10};
    a_if.req = 4'b1111;
    last     = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt("c_wait", g, at);
      chk("c_gnt", 32'(g), 32'(1 << k));
      if (k > 0)
        chk("c_space", 32'(at - last), 32'd4);
      last        = at;
      a_if.req[k] = 1'b0;
      step();
      chk("c_q",     32'(a_if.Q),     32'(exp_q[k]));
      chk("c_owner", 32'(a_if.owner), 32'(k));
    end

    // wrap: ptr is back at 0 after requester 3
    a_if.req = 4'b1001;
    wait_gnt("w_wait0", g, at);
    chk("w_gnt0", 32'(g), 32'h1);
    a_if.req = 4'b1000;
    wait_gnt("w_wait3", g, at);
    chk("w_gnt3", 32'(g), 32'h8);
`ifdef REG_ARBITER_PRIO0_EN
    a_if.req = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      wait_gnt("p_wait", g, at);
      chk("p_gnt0", 32'(g), 32'h1);
    end
    a_if.req = 4'b0010;
    wait_gnt("p_wait1", g, at);
    chk("p_gnt1", 32'(g), 32'h2);
`else
    a_if.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("r_wait", g, at);
      chk("r_gnt", 32'(g), 32'(1 << (k % 4)));
    end
`endif
    a_if.req = 4'b0000;
    repeat (5) step();

    // reset during the GRANT cycle
    do_reset();
    a_if.D   = {8'h00, 8'hFF, 8'h00, 8'h11};
    a_if.req = 4'b0100;
    step();
    chk("m_gnt", 32'(a_if.gnt), 32'h4);
    rst      = 1'b1;
    a_if.req = 4'b0000;
    step();
    chk("m_q",    32'(a_if.Q),    32'h0);
    chk("m_gnt0", 32'(a_if.gnt),  32'h0);
    chk("m_busy", 32'(a_if.busy), 32'h0);
    chk("m_upd",  32'(a_if.upd),  32'h0);
    rst      = 1'b0;
    a_if.req = 4'b0001;
    step();
    chk("m_gnt1", 32'(a_if.gnt), 32'h1);
    chk("m_q0",   32'(a_if.Q),   32'h0);
    a_if.req = 4'b0000;
    step();
    chk("m_q1",     32'(a_if.Q),     32'h11);
    chk("m_owner1", 32'(a_if.owner), 32'h0);

    // HOLD_CYC=0 instance, requester 2 held
    z_if.D   = {8'h00, 8'h5C, 8'h00, 8'h00};
    z_if.req = 4'b0100;
    step();
    chk("z_gnt_a", 32'(z_if.gnt),  32'h4);
    chk("z_upd_a", 32'(z_if.upd),  32'h0);
    step();
    chk("z_gnt_b", 32'(z_if.gnt),  32'h0);
    chk("z_upd_b", 32'(z_if.upd),  32'h1);
    chk("z_q",     32'(z_if.Q),    32'h5C);
    chk("z_busy",  32'(z_if.busy), 32'h0);
    step();
    chk("z_gnt_c", 32'(z_if.gnt), 32'h4);
    chk("z_upd_c", 32'(z_if.upd), 32'h0);
    step();
    chk("z_gnt_d", 32'(z_if.gnt), 32'h0);
    chk("z_upd_d", 32'(z_if.upd), 32'h1);
    z_if.req = 4'b0000;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, is the shared register data width in bits.
REQ-002 Parameter HOLD_CYC, default 2, is the lock cycles after each write (0..255).
REQ-003 clk  input  1  single clock; all logic is rising-edge triggered.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  4  request per requester; req[i] is held high until gnt[i] is seen.
REQ-006 D  input  4*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH]; stable while req[i] high.
REQ-007 gnt  output  4  one-hot grant, one-cycle pulse.
REQ-008 Q  output  WIDTH  shared register contents.
REQ-009 owner  output  2  index of the last granted requester.
REQ-010 upd  output  1  one-cycle pulse, high the cycle after Q loads.
REQ-011 busy  output  1  high in GRANT and HOLD states.

Function
REQ-012 FSM states: IDLE, GRANT, HOLD; encoding is free.
REQ-013 IDLE: with any req bit high at an edge, the winner is latched, the FSM enters GRANT, and gnt is the winner's one-hot value; with none high, the FSM stays in IDLE.
REQ-014 GRANT lasts exactly one cycle; at its closing edge Q loads the winner's D slice and owner loads the winner index.
REQ-015 After GRANT, the FSM enters HOLD for exactly HOLD_CYC cycles and then IDLE; with HOLD_CYC=0 it goes GRANT->IDLE directly.
REQ-016 Latency: req sampled at edge n -> gnt high in cycle n+1 -> new Q and upd in cycle n+2.
REQ-017 Minimum grant spacing is HOLD_CYC+2 cycles.
REQ-018 Round robin: search starts at pointer ptr and ascends 0..3 with wrap (3->0); after a grant, ptr = winner+1 mod 4.
REQ-019 Requests arriving or dropping during GRANT or HOLD are ignored until IDLE; a dropped req is never granted.
REQ-020 Q, owner and upd hold their values outside the load event; Q never changes outside GRANT's closing edge or reset.
REQ-021 All outputs are registered; no combinational path from req or D to any output.

Reset
REQ-022 rst high at an edge forces: state IDLE, gnt=0, Q=0, owner=0, upd=0, busy=0, ptr=0, hold counter=0.
REQ-023 Reset overrides everything, including mid-GRANT (no load of Q) and mid-HOLD (lock abandoned).
REQ-024 The first edge with rst low behaves as IDLE with ptr=0.

Configuration
REQ-025 Macro REG_ARBITER_PRIO0_EN, when defined, makes req[0] win whenever high in IDLE regardless of ptr; a requester-0 grant leaves ptr unchanged; other requesters are arbitrated round-robin among themselves from ptr.
REQ-026 Without REG_ARBITER_PRIO0_EN, all four requesters are pure round-robin per REQ-018.

Verification (WIDTH=8, HOLD_CYC=2)
REQ-027 Reset then single request: req=0010, D slice1=8'hA5 -> gnt=0010 one cycle later; Q=8'hA5, owner=1, upd=1 the next cycle; busy high 3 cycles.
REQ-028 Contention: req=1111 held, each requester dropping after its grant, slices 8'h10/8'h21/8'h32/8'h43 -> grant order 0,1,2,3; Q sequence 10,21,32,43; grants spaced 4 cycles.
REQ-029 Wrap: after owner=3, req=1001 -> requester 0 granted first, then 3; without the macro, req=1111 held constantly -> grants cycle 0,1,2,3,0.
REQ-030 Reset mid-operation: rst asserted in the GRANT cycle with slice2=8'hFF -> Q stays 0, gnt=0, busy=0; the next request from req=0001 is granted.
REQ-031 HOLD_CYC=0 build: req=0100 held -> gnt[2] pulses every 2 cycles; upd pulses follow each by 1 cycle.
REQ-032 With REG_ARBITER_PRIO0_EN and req=0011 constant -> requester 0 granted every time and ptr unchanged; dropping req[0] -> requester 1 is granted next.
